// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store access stage: bus size codes, FSM states
// and small helpers used by the top and the store-alignment sub-module.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_REQ    = 2'd1,
    MA_WAIT   = 2'd2,
    MA_CANCEL = 2'd3
  } ma_state_e;

  // Size code 3 is folded onto a word access everywhere downstream.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? MEM_SIZE_W : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == MEM_SIZE_H) bad = addr_lo[0];
    else if (size == MEM_SIZE_W) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Combinational store lane builder: byte strobes from size/offset and the
// right-aligned store data replicated across every lane it may land in.
module mem_access_unit_store_align
  import mem_access_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out
);

  always_comb begin
    wstrb     = 4'b1111;
    wdata_out = wdata;
    case (size)
      MEM_SIZE_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_out = {4{wdata[7:0]}};
      end
      MEM_SIZE_H: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata[15:0]}};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_out = wdata;
      end
    endcase
    // Loads never write, so they carry no strobes.
    if (!is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access stage driving an SRAM-like req/addr_ok/data_ok bus, one
// operation outstanding. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses
// (adel/ades) instead of silently aligning the bus address.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_is_store,
  input  logic [1:0]        op_size,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              ld_valid,
  output logic              ld_is_load,
  output logic [DATA_W-1:0] ld_word,
  output logic [1:0]        ld_ltype,
  output logic              busy,
  output logic              adel,
  output logic              ades,
  output logic [1:0]        dbg_state
);

  // Handshakes: an op transfers on a cycle with op_valid & op_ready (only in
  // IDLE, and never while flush is high); a bus request transfers on
  // data_req & data_addr_ok, and its response is the later data_ok pulse.

  ma_state_e state_q, state_d;

  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        ltype_q, ltype_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              ld_valid_q, ld_valid_d;
  logic              ld_is_load_q, ld_is_load_d;
  logic [DATA_W-1:0] ld_word_q, ld_word_d;
  logic [1:0]        ld_ltype_q, ld_ltype_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;

  logic [1:0]        op_size_n;
  logic [ADDR_W-1:0] bus_addr;
  logic              op_misaligned;
  logic              accept;
  logic              complete;
  logic [3:0]        sa_wstrb;
  logic [DATA_W-1:0] sa_wdata;

  assign op_size_n = norm_size(op_size);
  assign accept    = (state_q == MA_IDLE) & op_valid & ~flush;

  mem_access_unit_store_align u_store_align (
    .is_store  (op_is_store),
    .size      (op_size_n),
    .addr_lo   (op_addr[1:0]),
    .wdata     (op_wdata),
    .wstrb     (sa_wstrb),
    .wdata_out (sa_wdata)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign op_misaligned = is_misaligned(op_size_n, op_addr[1:0]);
  assign bus_addr      = op_addr;
`else
  assign op_misaligned = 1'b0;
  // Without the trap, the bus sees a naturally aligned address; the original
  // offset still travels to the extension stage through ld_ltype.
  always_comb begin
    bus_addr = op_addr;
    if (op_size_n == MEM_SIZE_W) bus_addr[1:0] = 2'b00;
    else if (op_size_n == MEM_SIZE_H) bus_addr[0] = 1'b0;
  end
`endif

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    addr_d       = addr_q;
    ltype_d      = ltype_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    ld_valid_d   = 1'b0;
    ld_is_load_d = ld_is_load_q;
    ld_word_d    = ld_word_q;
    ld_ltype_d   = ld_ltype_q;
    adel_d       = 1'b0;
    ades_d       = 1'b0;
    data_req     = 1'b0;
    complete     = 1'b0;

    case (state_q)
      MA_IDLE: begin
        if (accept) begin
          if (op_misaligned) begin
            adel_d = ~op_is_store;
            ades_d = op_is_store;
          end else begin
            is_store_d = op_is_store;
            size_d     = op_size_n;
            addr_d     = bus_addr;
            ltype_d    = op_addr[1:0];
            wstrb_d    = sa_wstrb;
            wdata_d    = sa_wdata;
            state_d    = MA_REQ;
          end
        end
      end
      MA_REQ: begin
        data_req = 1'b1;
        if (flush) begin
          // Once the address is taken a response is owed and must be drained.
          state_d = (data_addr_ok & ~data_data_ok) ? MA_CANCEL : MA_IDLE;
        end else if (data_addr_ok) begin
          if (data_data_ok) begin
            complete = 1'b1;
            state_d  = MA_IDLE;
          end else begin
            state_d = MA_WAIT;
          end
        end
      end
      MA_WAIT: begin
        if (data_data_ok) begin
          complete = ~flush;
          state_d  = MA_IDLE;
        end else if (flush) begin
          state_d = MA_CANCEL;
        end
      end
      MA_CANCEL: begin
        if (data_data_ok) state_d = MA_IDLE;
      end
      default: state_d = MA_IDLE;
    endcase

    if (complete) begin
      ld_valid_d   = 1'b1;
      ld_is_load_d = ~is_store_q;
      ld_word_d    = is_store_q ? '0 : data_rdata;
      ld_ltype_d   = ltype_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= MA_IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      ltype_q      <= 2'b00;
      wstrb_q      <= 4'b0000;
      wdata_q      <= '0;
      ld_valid_q   <= 1'b0;
      ld_is_load_q <= 1'b0;
      ld_word_q    <= '0;
      ld_ltype_q   <= 2'b00;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      ltype_q      <= ltype_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      ld_valid_q   <= ld_valid_d;
      ld_is_load_q <= ld_is_load_d;
      ld_word_q    <= ld_word_d;
      ld_ltype_q   <= ld_ltype_d;
      adel_q       <= adel_d;
      ades_q       <= ades_d;
    end
  end

  assign op_ready   = (state_q == MA_IDLE);
  assign busy       = (state_q != MA_IDLE) | (op_valid & op_ready);
  assign data_wr    = is_store_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wstrb = wstrb_q;
  assign data_wdata = wdata_q;
  assign ld_valid   = ld_valid_q;
  assign ld_is_load = ld_is_load_q;
  assign ld_word    = ld_word_q;
  assign ld_ltype   = ld_ltype_q;
  assign adel       = adel_q;
  assign ades       = ades_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: linear steps, inputs driven and outputs
// checked on the falling edge, expected values worked out by hand.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic        op_ready;
  logic        op_is_store;
  logic [1:0]  op_size;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        ld_valid;
  logic        ld_is_load;
  logic [31:0] ld_word;
  logic [1:0]  ld_ltype;
  logic        busy;
  logic        adel;
  logic        ades;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_is_store  (op_is_store),
    .op_size      (op_size),
    .op_addr      (op_addr),
    .op_wdata     (op_wdata),
    .flush        (flush),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .ld_valid     (ld_valid),
    .ld_is_load   (ld_is_load),
    .ld_word      (ld_word),
    .ld_ltype     (ld_ltype),
    .busy         (busy),
    .adel         (adel),
    .ades         (ades),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle_inputs();
    op_valid     = 1'b0;
    op_is_store  = 1'b0;
    op_size      = 2'd0;
    op_addr      = 32'h0;
    op_wdata     = 32'h0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
  endtask

  task automatic drive_op(input logic st, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    op_valid    = 1'b1;
    op_is_store = st;
    op_size     = sz;
    op_addr     = a;
    op_wdata    = wd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    resetn = 1'b0;

    // Reset state
    #2;
    chk("rst_op_ready", 32'(op_ready), 1);
    chk("rst_data_req", 32'(data_req), 0);
    chk("rst_ld_valid", 32'(ld_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 32'(MA_IDLE));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Load word 0x100, addr_ok+data_ok with the request
    @(negedge clk);
    drive_op(1'b0, 2'd2, 32'h100, 32'h0);
    #1;
    chk("lw_op_ready", 32'(op_ready), 1);
    chk("lw_busy_accept", 32'(busy), 1);
    @(negedge clk);
    idle_inputs();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEADBEEF;
    #1;
    chk("lw_req", 32'(data_req), 1);
    chk("lw_addr", data_addr, 32'h100);
    chk("lw_wstrb", 32'(data_wstrb), 0);
    chk("lw_wr", 32'(data_wr), 0);
    chk("lw_size", 32'(data_size), 2);
    chk("lw_no_early_valid", 32'(ld_valid), 0);
    chk("lw_op_ready_busy", 32'(op_ready), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("lw_ld_valid", 32'(ld_valid), 1);
    chk("lw_ld_word", ld_word, 32'hDEADBEEF);
    chk("lw_ld_ltype", 32'(ld_ltype), 0);
    chk("lw_ld_is_load", 32'(ld_is_load), 1);
    chk("lw_req_drop", 32'(data_req), 0);
    @(negedge clk);
    #1;
    chk("lw_valid_one_cycle", 32'(ld_valid), 0);

    // Store byte 0xA5 to 0x203, addr_ok on 3rd req cycle, data_ok 2 cycles later
    @(negedge clk);
    drive_op(1'b1, 2'd0, 32'h203, 32'h777777A5);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      data_addr_ok = (i == 2);
      #1;
      chk("sb_req_held", 32'(data_req), 1);
      chk("sb_wstrb", 32'(data_wstrb), 32'h8);
      chk("sb_wdata", data_wdata, 32'hA5A5A5A5);
      chk("sb_wr", 32'(data_wr), 1);
      chk("sb_addr", data_addr, 32'h203);
    end
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("sb_wait_req", 32'(data_req), 0);
    chk("sb_wait_state", 32'(dbg_state), 32'(MA_WAIT));
    @(negedge clk);
    data_data_ok = 1'b1;
    #1;
    chk("sb_wait_no_valid", 32'(ld_valid), 0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("sb_ld_valid", 32'(ld_valid), 1);
    chk("sb_ld_is_load", 32'(ld_is_load), 0);
    chk("sb_ld_word", ld_word, 32'h0);
    chk("sb_ld_ltype", 32'(ld_ltype), 3);

    // Load half 0x0A, flush in WAIT, then late data_ok drained in CANCEL
    @(negedge clk);
    drive_op(1'b0, 2'd1, 32'h0A, 32'h0);
    @(negedge clk);
    idle_inputs();
    data_addr_ok = 1'b1;
    #1;
    chk("lh_req", 32'(data_req), 1);
    chk("lh_addr", data_addr, 32'h0A);
    chk("lh_size", 32'(data_size), 1);
    @(negedge clk);
    data_addr_ok = 1'b0;
    flush        = 1'b1;
    #1;
    chk("lh_wait_state", 32'(dbg_state), 32'(MA_WAIT));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("lh_cancel_state", 32'(dbg_state), 32'(MA_CANCEL));
    chk("lh_cancel_not_ready", 32'(op_ready), 0);
    chk("lh_cancel_busy", 32'(busy), 1);
    @(negedge clk);
    data_data_ok = 1'b1;
    data_rdata   = 32'h11111111;
    #1;
    chk("lh_cancel_hold", 32'(dbg_state), 32'(MA_CANCEL));
    @(negedge clk);
    idle_inputs();
    drive_op(1'b0, 2'd2, 32'h500, 32'h0);
    #1;
    chk("lh_no_valid", 32'(ld_valid), 0);
    chk("lh_back_idle", 32'(dbg_state), 32'(MA_IDLE));
    chk("lh_ready_again", 32'(op_ready), 1);
    @(negedge clk);
    idle_inputs();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0BADCAFE;
    #1;
    chk("lh_next_req", 32'(dbg_state), 32'(MA_REQ));
    chk("lh_next_addr", data_addr, 32'h500);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("lh_next_valid", 32'(ld_valid), 1);
    chk("lh_next_word", ld_word, 32'h0BADCAFE);

    // Flush in REQ before addr_ok, then flush with op_valid in IDLE
    @(negedge clk);
    drive_op(1'b0, 2'd2, 32'h300, 32'h0);
    @(negedge clk);
    idle_inputs();
    flush = 1'b1;
    #1;
    chk("fr_req", 32'(data_req), 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fr_req_dropped", 32'(data_req), 0);
    chk("fr_idle", 32'(dbg_state), 32'(MA_IDLE));
    @(negedge clk);
    drive_op(1'b0, 2'd2, 32'h600, 32'h0);
    flush = 1'b1;
    #1;
    chk("fr_no_completion", 32'(ld_valid), 0);
    chk("fi_op_ready", 32'(op_ready), 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fi_not_latched_state", 32'(dbg_state), 32'(MA_IDLE));
    chk("fi_no_req", 32'(data_req), 0);
    chk("fi_addr_kept", data_addr, 32'h300);

    // Reset asserted in WAIT, late data_ok after release
    @(negedge clk);
    drive_op(1'b1, 2'd2, 32'h400, 32'hCAFEF00D);
    @(negedge clk);
    idle_inputs();
    data_addr_ok = 1'b1;
    #1;
    chk("rw_wstrb", 32'(data_wstrb), 32'hF);
    chk("rw_wdata", data_wdata, 32'hCAFEF00D);
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("rw_wait", 32'(dbg_state), 32'(MA_WAIT));
    resetn = 1'b0;
    #1;
    chk("rw_req", 32'(data_req), 0);
    chk("rw_wr", 32'(data_wr), 0);
    chk("rw_addr", data_addr, 32'h0);
    chk("rw_wstrb0", 32'(data_wstrb), 0);
    chk("rw_wdata0", data_wdata, 32'h0);
    chk("rw_size", 32'(data_size), 0);
    chk("rw_busy", 32'(busy), 0);
    chk("rw_op_ready", 32'(op_ready), 1);
    chk("rw_state", 32'(dbg_state), 32'(MA_IDLE));
    @(negedge clk);
    resetn       = 1'b1;
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("rw_late_no_valid", 32'(ld_valid), 0);
    chk("rw_late_idle", 32'(dbg_state), 32'(MA_IDLE));

    // Store half 0x1234 to 0x06
    @(negedge clk);
    drive_op(1'b1, 2'd1, 32'h06, 32'hFFFF1234);
    @(negedge clk);
    idle_inputs();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    #1;
    chk("sh_wstrb", 32'(data_wstrb), 32'hC);
    chk("sh_wdata", data_wdata, 32'h12341234);
    chk("sh_addr", data_addr, 32'h06);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("sh_valid", 32'(ld_valid), 1);
    chk("sh_is_load", 32'(ld_is_load), 0);

    // Misaligned load word at 0x102
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    drive_op(1'b0, 2'd2, 32'h102, 32'h0);
    #1;
    chk("mis_op_ready", 32'(op_ready), 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_adel", 32'(adel), 1);
    chk("mis_ades", 32'(ades), 0);
    chk("mis_no_req", 32'(data_req), 0);
    chk("mis_idle", 32'(dbg_state), 32'(MA_IDLE));
    @(negedge clk);
    #1;
    chk("mis_adel_pulse", 32'(adel), 0);
    chk("mis_no_valid", 32'(ld_valid), 0);
    chk("mis_no_req2", 32'(data_req), 0);
`else
    @(negedge clk);
    drive_op(1'b0, 2'd2, 32'h102, 32'h0);
    @(negedge clk);
    idle_inputs();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    data_rdata   = 32'h22223333;
    #1;
    chk("mis_addr_aligned", data_addr, 32'h100);
    chk("mis_adel_tied", 32'(adel), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_valid", 32'(ld_valid), 1);
    chk("mis_ltype", 32'(ld_ltype), 2);
    chk("mis_word", ld_word, 32'h22223333);
    chk("mis_ades_tied", 32'(ades), 0);
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store access stage directly upstream of the load-extension stage. It takes one memory operation per handshake from the execute stage and drives an SRAM-like data bus (req/addr_ok/data_ok). For stores it builds byte strobes and lane-replicated write data. For loads it returns the raw 32-bit bus word plus the byte offset, which the extension stage uses to select the lane.

Parameters:
ADDR_W, 32, byte address width of op_addr and data_addr.
DATA_W, 32, bus data width; only 32 is supported.

Ports:
clk  in  1  clock, all state changes on rising edge
resetn  in  1  asynchronous active-low reset
op_valid  in  1  execute stage presents an operation
op_ready  out  1  unit accepts the operation this cycle
op_is_store  in  1  1 = store, 0 = load
op_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
op_addr  in  ADDR_W  byte address
op_wdata  in  DATA_W  store data, right-aligned
flush  in  1  cancel the in-flight operation (exception/redirect)
data_req  out  1  bus request
data_wr  out  1  bus write
data_size  out  2  bus size, same encoding as op_size
data_addr  out  ADDR_W  bus address
data_wstrb  out  4  byte strobes
data_wdata  out  DATA_W  lane-replicated write data
data_addr_ok  in  1  bus accepted the address
data_data_ok  in  1  bus returned data / write done
data_rdata  in  DATA_W  read data
ld_valid  out  1  one-cycle completion pulse
ld_is_load  out  1  completing operation was a load
ld_word  out  DATA_W  raw read word, fed to the extension stage
ld_ltype  out  2  op_addr[1:0] of the completing operation
busy  out  1  pipeline stall request
adel  out  1  load address error pulse (optional feature)
ades  out  1  store address error pulse (optional feature)

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE.
  - All outputs are 0, except op_ready=1.
  - Latched op fields are cleared.
- States: IDLE, REQ, WAIT, CANCEL.
- IDLE:
  - op_ready=1.
  - op_valid & ~flush: latch the op; next state REQ.
  - op_valid & flush: the op is not accepted.
- REQ:
  - data_req=1. data_wr, data_size, data_addr, data_wstrb and data_wdata are held stable from the latch.
  - addr_ok & data_ok in the same cycle: complete, next state IDLE.
  - addr_ok only: next state WAIT.
  - flush before addr_ok: drop the request; next state IDLE; no completion.
- WAIT:
  - data_req=0.
  - data_ok: complete, next state IDLE.
  - flush without data_ok: next state CANCEL.
  - flush together with data_ok: next state IDLE; completion is suppressed.
- CANCEL: wait for data_ok and discard it; next state IDLE; no ld_valid.
- Completion:
  - ld_valid is registered and high for exactly one cycle after the data_ok cycle.
  - ld_word captures data_rdata (loads; 0 for stores).
  - ld_ltype = latched addr[1:0]; ld_is_load = ~is_store.
  - Minimum latency: accept in cycle t, request in t+1, ld_valid in t+2.
- busy = (state != IDLE) | (op_valid & op_ready). busy stays 0 when op_valid=0.
- Store strobes and data:
  - byte: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111; wdata unchanged.
  - Loads: wstrb = 0.
- data_addr = latched addr unmodified. The bus returns the full word; lane selection is downstream.
- Only one outstanding operation at a time. op_ready=0 in every state except IDLE.

Optional Feature:
MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an op that is half with addr[0]=1, or word with addr[1:0]!=0, is accepted but never reaches the bus.
  - adel (load) or ades (store) pulses one cycle later.
  - State stays IDLE; ld_valid stays 0.
- Undefined:
  - adel and ades are tied to 0.
  - data_addr low bits are forced aligned: half clears bit 0, word clears bits 1:0. ld_ltype is unchanged.

Decomposition:
- The shared defines header holds:
  - MEM_SIZE_B/H/W encodings (0/1/2).
  - FSM state encodings MA_IDLE/REQ/WAIT/CANCEL.
- One combinational sub-module, store_align (size, addr[1:0], wdata -> wstrb, wdata), instantiated once in front of the request latch.

Test Plan:
- Load word at 0x100; addr_ok and data_ok in the same cycle as the req, rdata 0xDEADBEEF -> ld_valid in cycle t+2, ld_word=0xDEADBEEF, ld_ltype=0, data_wstrb=0.
- Store byte 0xA5 to 0x203; addr_ok after 3 cycles, data_ok 2 cycles later -> data_wstrb=4'b1000, data_wdata=0xA5A5A5A5, req held 3 cycles, ld_valid with ld_is_load=0.
- Load half at 0x0A; addr_ok, then flush in WAIT, then data_ok -> state passes through CANCEL, no ld_valid, next op accepted after data_ok.
- Flush in REQ before addr_ok -> data_req drops next cycle, IDLE, no completion; with flush and op_valid together in IDLE -> op_ready high but op not latched, no req.
- resetn asserted low in WAIT -> all outputs 0 immediately; after release a late data_ok produces no ld_valid.
- MEM_ALIGN_CHECK_EN defined, load word at 0x102 -> adel pulses once, data_req never asserts; undefined -> data_addr=0x100, ld_ltype=2.
